// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: 8x8 register file, operand selection and load-use/RAW stall detection.
// Build option: define ID_EX_FWD_EN to enable EX/MEM/WB forwarding. When it is undefined,
// operands come only from the register file with its write-first bypass, and RAW hazards stall.
module id_ex_stage #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic [DW-1:0] imm,
  input  logic          use_imm,
  input  logic          is_load,
  input  logic          reg_wr,
  input  logic [DW-1:0] alu_res,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_wr,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_wr,
  input  logic [DW-1:0] wb_data,
  input  logic          stall_in,
  input  logic          flush,
  output logic [DW-1:0] num1,
  output logic [DW-1:0] num2,
  output logic [AW-1:0] rd_ex,
  output logic          reg_wr_ex,
  output logic          is_load_ex,
  output logic          valid_ex,
  output logic          hazard_stall
);

  logic [DW-1:0] rf_q [NREG];

  logic [DW-1:0] num1_q, num1_d, num2_q, num2_d;
  logic [AW-1:0] rd_ex_q, rd_ex_d;
  logic          reg_wr_ex_q, reg_wr_ex_d;
  logic          is_load_ex_q, is_load_ex_d;
  logic          valid_ex_q, valid_ex_d;

  logic [DW-1:0] rf1, rf2;
  logic [DW-1:0] op1, op2;
  logic          ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  // Register file write port; R0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_wr && (wb_rd != '0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Register file reads with write-first bypass of the WB port.
  always_comb begin
    rf1 = rf_q[rs1];
    if (wb_wr && (wb_rd == rs1)) rf1 = wb_data;
    if (rs1 == '0) rf1 = '0;
    rf2 = rf_q[rs2];
    if (wb_wr && (wb_rd == rs2)) rf2 = wb_data;
    if (rs2 == '0) rf2 = '0;
  end

  // Producer matches in EX and MEM; R0 never matches.
  assign ex_hit1  = valid_ex_q && reg_wr_ex_q && (rd_ex_q == rs1) && (rs1 != '0);
  assign ex_hit2  = valid_ex_q && reg_wr_ex_q && (rd_ex_q == rs2) && (rs2 != '0);
  assign mem_hit1 = mem_wr && (mem_rd == rs1) && (rs1 != '0);
  assign mem_hit2 = mem_wr && (mem_rd == rs2) && (rs2 != '0);

`ifdef ID_EX_FWD_EN
  logic ld_hit;

  // EX beats MEM; the WB path is the register file's write-first bypass.
  always_comb begin
    op1 = rf1;
    if (mem_hit1) op1 = mem_data;
    if (ex_hit1)  op1 = alu_res;
    op2 = rf2;
    if (mem_hit2) op2 = mem_data;
    if (ex_hit2)  op2 = alu_res;
    if (use_imm)  op2 = imm;
  end

  // Only a load in EX cannot be forwarded in time.
  assign ld_hit = in_valid && valid_ex_q && is_load_ex_q && (rd_ex_q != '0) &&
                  ((rd_ex_q == rs1) || (!use_imm && (rd_ex_q == rs2)));
  assign hazard_stall = ld_hit;
`else
  logic unused_fwd;

  // No forwarding: register file only.
  always_comb begin
    op1 = rf1;
    op2 = use_imm ? imm : rf2;
  end

  // Any pending EX or MEM producer of an active source stalls until it reaches WB.
  assign hazard_stall = in_valid &&
                        (ex_hit1 || mem_hit1 || (!use_imm && (ex_hit2 || mem_hit2)));
  assign unused_fwd   = ^{alu_res, mem_data};
`endif

  // ID/EX next state: flush > stall_in > hazard bubble > load.
  always_comb begin
    num1_d       = num1_q;
    num2_d       = num2_q;
    rd_ex_d      = rd_ex_q;
    reg_wr_ex_d  = reg_wr_ex_q;
    is_load_ex_d = is_load_ex_q;
    valid_ex_d   = valid_ex_q;
    if (flush || (!stall_in && hazard_stall)) begin
      num1_d       = '0;
      num2_d       = '0;
      rd_ex_d      = '0;
      reg_wr_ex_d  = 1'b0;
      is_load_ex_d = 1'b0;
      valid_ex_d   = 1'b0;
    end else if (!stall_in) begin
      num1_d       = op1;
      num2_d       = op2;
      rd_ex_d      = rd;
      reg_wr_ex_d  = reg_wr && in_valid;
      is_load_ex_d = is_load && in_valid;
      valid_ex_d   = in_valid;
    end
  end

  // ID/EX pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num1_q       <= '0;
      num2_q       <= '0;
      rd_ex_q      <= '0;
      reg_wr_ex_q  <= 1'b0;
      is_load_ex_q <= 1'b0;
      valid_ex_q   <= 1'b0;
    end else begin
      num1_q       <= num1_d;
      num2_q       <= num2_d;
      rd_ex_q      <= rd_ex_d;
      reg_wr_ex_q  <= reg_wr_ex_d;
      is_load_ex_q <= is_load_ex_d;
      valid_ex_q   <= valid_ex_d;
    end
  end

  assign num1       = num1_q;
  assign num2       = num2_q;
  assign rd_ex      = rd_ex_q;
  assign reg_wr_ex  = reg_wr_ex_q;
  assign is_load_ex = is_load_ex_q;
  assign valid_ex   = valid_ex_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: the bench plays EX/MEM/WB around the DUT and checks issued
// operands against an architectural register model through a scoreboard queue.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam int ExpRawHz = 0;
  localparam int ExpLdHz  = 1;
`else
  localparam int ExpRawHz = 2;
  localparam int ExpLdHz  = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, use_imm, is_load, reg_wr, stall_in, flush;
  logic [2:0] rs1, rs2, rd;
  logic [7:0] imm;
  logic [7:0] alu_res, mem_data, wb_data;
  logic [2:0] mem_rd, wb_rd;
  logic       mem_wr, wb_wr;
  logic [7:0] num1, num2;
  logic [2:0] rd_ex;
  logic       reg_wr_ex, is_load_ex, valid_ex, hazard_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .use_imm(use_imm), .is_load(is_load), .reg_wr(reg_wr), .alu_res(alu_res),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data(mem_data), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .wb_data(wb_data), .stall_in(stall_in), .flush(flush), .num1(num1), .num2(num2),
    .rd_ex(rd_ex), .reg_wr_ex(reg_wr_ex), .is_load_ex(is_load_ex), .valid_ex(valid_ex),
    .hazard_stall(hazard_stall)
  );

  typedef struct packed {
    logic [2:0] rs1, rs2, rd;
    logic [7:0] imm;
    logic       use_imm, is_load, reg_wr;
  } instr_t;

  typedef struct packed {
    logic [7:0] n1, n2;
    logic [2:0] rd;
    logic       rw, ld;
  } exp_t;

  exp_t       exq[$];
  logic [7:0] arch [8];
  int         checks = 0;
  int         errors = 0;

  // Data memory contents seen by loads: a fixed scramble of the address.
  function automatic logic [7:0] memfn(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream stages modelled by the bench: EX adds, MEM loads, WB writes back.
  assign alu_res = num1 + num2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr <= 1'b0; mem_rd <= '0; mem_data <= '0;
      wb_wr  <= 1'b0; wb_rd  <= '0; wb_data  <= '0;
    end else if (!stall_in) begin
      mem_wr   <= valid_ex && reg_wr_ex;
      mem_rd   <= rd_ex;
      mem_data <= is_load_ex ? memfn(alu_res) : alu_res;
      wb_wr    <= mem_wr;
      wb_rd    <= mem_rd;
      wb_data  <= mem_data;
    end
  end

  function automatic instr_t rand_instr();
    instr_t i;
    i.rs1     = 3'($urandom_range(0, 7));
    i.rs2     = 3'($urandom_range(0, 7));
    i.rd      = 3'($urandom_range(0, 7));
    i.imm     = 8'($urandom);
    i.is_load = ($urandom_range(0, 3) == 0);
    i.use_imm = i.is_load ? 1'b1 : 1'($urandom_range(0, 1));
    i.reg_wr  = ($urandom_range(0, 4) != 0);
    return i;
  endfunction

  function automatic instr_t mk(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] d,
                                input logic [7:0] im, input logic ui, input logic ld,
                                input logic rw);
    instr_t i;
    i.rs1 = r1; i.rs2 = r2; i.rd = d; i.imm = im; i.use_imm = ui; i.is_load = ld; i.reg_wr = rw;
    return i;
  endfunction

  // Present one instruction until accepted or flushed. Entered just after a rising edge.
  // mode: 0 plain, 1 random stall/flush, 2 one forced stall cycle, 3 one flush+stall cycle.
  task automatic drive(input instr_t ins, input bit v, input int mode, output int hz_cnt);
    bit   done, acc, st, fl;
    int   iter;
    exp_t e;
    hz_cnt = 0; done = 0; iter = 0; e = '0;
    while (!done) begin
      #1;
      st = 0; fl = 0;
      case (mode)
        1: begin st = ($urandom_range(0, 5) == 0); fl = !st && ($urandom_range(0, 9) == 0); end
        2: st = 1;
        3: begin st = 1; fl = 1; end
        default: ;
      endcase
      in_valid = v; rs1 = ins.rs1; rs2 = ins.rs2; rd = ins.rd; imm = ins.imm;
      use_imm = ins.use_imm; is_load = ins.is_load; reg_wr = ins.reg_wr;
      stall_in = st; flush = fl;
      @(negedge clk);
      acc = 0;
      if (mode >= 2 || fl) done = 1;
      else if (st) ;
      else if (hazard_stall) hz_cnt++;
      else begin
        done = 1;
        acc  = v;
        if (v) begin
          e.n1 = arch[ins.rs1];
          e.n2 = ins.use_imm ? ins.imm : arch[ins.rs2];
          e.rd = ins.rd; e.rw = ins.reg_wr; e.ld = ins.is_load;
          if (ins.reg_wr && ins.rd != 0)
            arch[ins.rd] = ins.is_load ? memfn(e.n1 + e.n2) : 8'(e.n1 + e.n2);
        end
      end
      iter++;
      if (!done && iter >= 40) begin
        checks++; errors++;
        $display("FAIL issue_timeout: instruction never accepted after %0d cycles", iter);
        done = 1;
      end
      @(posedge clk);
      if (acc) exq.push_back(e);
    end
  endtask

  // Monitor: judges what the previous edge loaded into EX.
  initial begin
    bit         p_st, p_fl, p_hz;
    logic [21:0] snap;
    exp_t       e;
    p_st = 0; p_fl = 1; p_hz = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_st = 0; p_fl = 1; p_hz = 0;
      end else begin
        if (p_st && !p_fl) begin
          check("hold", {num1, num2, rd_ex, reg_wr_ex, is_load_ex, valid_ex}, snap);
        end else if (valid_ex) begin
          if (exq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: valid_ex=1 with nothing issued, num1=%0h", num1);
          end else begin
            e = exq.pop_front();
            check("operands", {num1, num2, rd_ex, reg_wr_ex, is_load_ex}, e);
          end
        end else if (p_fl || p_hz) begin
          check("bubble", {num1, num2, rd_ex, reg_wr_ex, is_load_ex}, 0);
        end else begin
          check("idle", {reg_wr_ex, is_load_ex}, 0);
        end
        p_st = stall_in; p_fl = flush; p_hz = hazard_stall;
      end
      snap = {num1, num2, rd_ex, reg_wr_ex, is_load_ex, valid_ex};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hz;
    reset_n = 0; in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; imm = 0;
    use_imm = 0; is_load = 0; reg_wr = 0; stall_in = 0; flush = 0;
    for (int i = 0; i < 8; i++) arch[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {num1, num2, rd_ex, reg_wr_ex, is_load_ex, valid_ex, hazard_stall}, 0);
    @(posedge clk);
    #2 reset_n = 1;
    @(posedge clk);

    // Directed: R0 handling, RAW and load-use stall counts, EX-over-MEM priority.
    drive(mk(3'd3, 3'd0, 3'd0, 8'h00, 1, 0, 0), 1, 0, hz);
    drive(mk(3'd0, 3'd0, 3'd0, 8'hFF, 1, 0, 1), 1, 0, hz);
    drive(mk(3'd0, 3'd0, 3'd6, 8'h00, 0, 0, 1), 1, 0, hz);
    check("r0_no_hazard", hz, 0);
    drive(mk(3'd0, 3'd0, 3'd1, 8'h21, 1, 0, 1), 1, 0, hz);
    drive(mk(3'd1, 3'd0, 3'd2, 8'h02, 1, 0, 1), 1, 0, hz);
    check("raw_hazard_cycles", hz, ExpRawHz);
    drive(mk(3'd0, 3'd0, 3'd5, 8'h40, 1, 1, 1), 1, 0, hz);
    drive(mk(3'd5, 3'd0, 3'd3, 8'h01, 1, 0, 1), 1, 0, hz);
    check("load_use_cycles", hz, ExpLdHz);
    drive(mk(3'd0, 3'd0, 3'd4, 8'h22, 1, 0, 1), 1, 0, hz);
    drive(mk(3'd0, 3'd0, 3'd4, 8'h11, 1, 0, 1), 1, 0, hz);
    drive(mk(3'd4, 3'd4, 3'd7, 8'h00, 0, 0, 1), 1, 0, hz);
    check("ex_prio_hazard_cycles", hz, ExpRawHz);

    // Random traffic with stalls, flushes and idle slots.
    for (int n = 0; n < 150; n++) drive(rand_instr(), ($urandom_range(0, 7) != 0), 1, hz);

    // Asynchronous reset mid-stream.
    #3 reset_n = 0;
    #1;
    check("midrun_reset", {num1, num2, rd_ex, reg_wr_ex, is_load_ex, valid_ex}, 0);
    exq.delete();
    for (int i = 0; i < 8; i++) arch[i] = 8'h00;
    in_valid = 0; stall_in = 0; flush = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(posedge clk);
    drive(mk(3'd3, 3'd0, 3'd0, 8'h00, 1, 0, 0), 1, 0, hz);

    for (int n = 0; n < 150; n++) drive(rand_instr(), ($urandom_range(0, 7) != 0), 1, hz);

    // Three-cycle freeze, then flush together with stall_in.
    drive(mk(3'd1, 3'd2, 3'd3, 8'h5A, 0, 0, 1), 1, 0, hz);
    for (int n = 0; n < 3; n++) drive(rand_instr(), 1, 2, hz);
    drive(mk(3'd2, 3'd0, 3'd6, 8'h33, 1, 0, 1), 1, 0, hz);
    drive(rand_instr(), 1, 3, hz);
    #1;
    check("flush_with_stall", valid_ex, 0);
    @(posedge clk);
    for (int n = 0; n < 4; n++) drive(rand_instr(), 0, 0, hz);
    #1;
    in_valid = 0;
    check("scoreboard_drained", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute stage of the 8-bit 4-stage pipeline (ID -> EX -> MEM -> WB).
- Holds the 8x8-bit register file and the ID/EX pipeline registers that drive the add-only ALU operands num1/num2.
- Resolves RAW hazards with forwarding from the EX, MEM and WB stages.
- Detects load-use hazards and requests a stall from IF/ID.

Parameters:
- DW, 8, data width of registers, operands and immediate.
- NREG, 8, register count; register index width is log2(NREG) = 3.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction present in ID
- rs1  input  3  source register 1
- rs2  input  3  source register 2
- rd  input  3  destination register
- imm  input  8  immediate / load offset (ImmData)
- use_imm  input  1  1: num2 = imm; 0: num2 = R[rs2]
- is_load  input  1  instruction is a load (address = R[rs1]+imm)
- reg_wr  input  1  instruction writes rd
- alu_res  input  8  combinational ALU result of the instruction now in EX
- mem_rd  input  3  MEM-stage destination
- mem_wr  input  1  MEM-stage writes mem_rd
- mem_data  input  8  MEM-stage final result (ALU or load data)
- wb_rd  input  3  WB destination
- wb_wr  input  1  WB write enable
- wb_data  input  8  WB write data
- stall_in  input  1  global pipeline freeze
- flush  input  1  kill the instruction in ID
- num1  output  8  ALU operand 1 (registered)
- num2  output  8  ALU operand 2 (registered)
- rd_ex  output  3  EX destination
- reg_wr_ex  output  1  EX write enable
- is_load_ex  output  1  EX is a load
- valid_ex  output  1  EX slot holds a real instruction
- hazard_stall  output  1  combinational; IF/ID must hold its instruction

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All ID/EX registers and outputs are 0.
  - All register-file entries are 0.
  - Takes effect mid-operation immediately; no pending write survives.
- Register file:
  - R0 always reads 0; writes to R0 are ignored; R0 is never a forwarding match.
  - Written on clk when wb_wr=1.
  - Write-first: a same-cycle read of wb_rd returns wb_data.
  - Writes happen regardless of stall_in or flush.
- Operand selection per source rsX, first match wins:
  - 1) EX: valid_ex & reg_wr_ex & rd_ex==rsX -> alu_res.
  - 2) MEM: mem_wr & mem_rd==rsX -> mem_data.
  - 3) WB: wb_wr & wb_rd==rsX -> wb_data.
  - 4) Register file.
  - rs2 is considered only when use_imm=0.
- Load-use hazard: hazard_stall = in_valid & valid_ex & is_load_ex & rd_ex!=0 & (rd_ex==rs1 | (!use_imm & rd_ex==rs2)).
- Register update priority on each clk:
  - flush: bubble, i.e. valid_ex, reg_wr_ex and is_load_ex = 0; num1, num2 and rd_ex = 0.
  - else stall_in: hold every ID/EX register.
  - else hazard_stall: bubble; the ID instruction is retried next cycle and then picks up the load result via MEM forwarding.
  - else: load the selected operands, rd, reg_wr&in_valid, is_load&in_valid, and in_valid.
- Latency: operands appear on num1/num2 one cycle after the instruction is presented in ID.
- Arithmetic: no computation in this block; operand widths are DW and no extension is performed.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding and the load-use rule as above.
- Undefined: no forwarding paths; only the register file (with its write-first bypass) supplies operands. hazard_stall additionally asserts on any RAW match of rs1 or active rs2 against the EX destination (valid_ex & reg_wr_ex) or the MEM destination (mem_wr), rd!=0. RAW hazards cost up to 2 bubbles.

Test Plan:
- Reset: reset_n=0 mid-stream -> every output is 0 immediately; a read of R3 afterwards returns 0.
- WB bypass: wb_wr=1, wb_rd=2, wb_data=0x5A, same cycle ID rs1=2, use_imm=1, imm=0x03 -> next cycle num1=0x5A, num2=0x03, valid_ex=1.
- EX forward priority: EX rd_ex=4 with alu_res=0x11, MEM mem_rd=4 with mem_data=0x22, ID rs1=4 -> num1=0x11. Repeat with rs2=4, use_imm=0 -> num2=0x11.
- Load-use: EX is a load to R5, ID rs1=5 -> hazard_stall=1 and a bubble is inserted (valid_ex=0). Next cycle, with mem_data=0x7E and mem_rd=5 -> num1=0x7E.
- R0, flush, stall:
  - rs1=0 while EX writes R0 with alu_res=0xFF -> num1=0.
  - flush=1 together with stall_in=1 -> bubble.
  - stall_in=1 alone -> outputs are unchanged for 3 cycles.
- ID_EX_FWD_EN undefined: ADD to R1, then an instruction reading R1 -> hazard_stall=1 for exactly 2 cycles; num1 then equals the R1 value taken from the register file.
